// File: rtl/noc_pkt_pkg.sv
// ---------------------------------------------------------------------------
// noc_pkt_pkg
// Shared definitions for the leaf credit protocol.
//   - Default field widths of a NoC packet and the bit offsets of each field
//     for that default layout (MSB to LSB: valid, dst_leaf, dst_port, addr,
//     payload).
//   - Port numbering split: input ports are 1..INPUT_PORT_MAX_NUM, output
//     ports start at OUTPUT_PORT_MIN_NUM.
//   - Transmit-endpoint state encoding.
// ---------------------------------------------------------------------------
package noc_pkt_pkg;

    localparam int NOC_LEAF_BITS       = 6;
    localparam int NOC_PORT_BITS       = 4;
    localparam int NOC_ADDR_BITS       = 7;
    localparam int NOC_PAYLOAD_BITS    = 64;
    localparam int NOC_PACKET_BITS     = 1 + NOC_LEAF_BITS + NOC_PORT_BITS
                                         + NOC_ADDR_BITS + NOC_PAYLOAD_BITS;

    // Field offsets (LSB of each field) for the default layout.
    localparam int PKT_PAYLOAD_LSB     = 0;
    localparam int PKT_ADDR_LSB        = PKT_PAYLOAD_LSB + NOC_PAYLOAD_BITS;
    localparam int PKT_PORT_LSB        = PKT_ADDR_LSB + NOC_ADDR_BITS;
    localparam int PKT_LEAF_LSB        = PKT_PORT_LSB + NOC_PORT_BITS;
    localparam int PKT_VALID_BIT       = PKT_LEAF_LSB + NOC_LEAF_BITS;

    localparam int INPUT_PORT_MAX_NUM  = 8;
    localparam int OUTPUT_PORT_MIN_NUM = 9;

    typedef enum logic [0:0] {
        CFG_WAIT = 1'b0,
        RUN      = 1'b1
    } tx_state_e;

endpackage

// File: rtl/credit_stream_tx_if.sv
// ---------------------------------------------------------------------------
// credit_stream_tx_if
// Bundles the data-path signals of the credit transmit endpoint.
//   din       user data word
//   vld_user  user word valid
//   ack_user  word accepted this cycle when vld_user && ack_user
//   stream_in incoming packets (freespace updates), valid when MSB = 1
//   pkt_out   head packet toward the converge arbiter
//   pkt_vld   head packet valid
//   pkt_rd    arbiter grant, pops the head packet
//
// Handshakes: a user word transfers on any cycle where vld_user and ack_user
// are both 1; a packet transfers on any cycle where pkt_vld and pkt_rd are
// both 1 (pkt_rd with pkt_vld low does nothing). Neither ready depends
// combinationally on its valid.
//
// Modports: master = user logic / arbiter / network side, slave = endpoint.
// ---------------------------------------------------------------------------
interface credit_stream_tx_if #(
    parameter int PAYLOAD_BITS = 64,
    parameter int PACKET_BITS  = 82
);
    logic [PAYLOAD_BITS-1:0] din;
    logic                    vld_user;
    logic                    ack_user;
    logic [PACKET_BITS-1:0]  stream_in;
    logic [PACKET_BITS-1:0]  pkt_out;
    logic                    pkt_vld;
    logic                    pkt_rd;

    modport master (
        output din, vld_user, stream_in, pkt_rd,
        input  ack_user, pkt_out, pkt_vld
    );

    modport slave (
        input  din, vld_user, stream_in, pkt_rd,
        output ack_user, pkt_out, pkt_vld
    );
endinterface

// File: rtl/credit_tx_fifo2.sv
// ---------------------------------------------------------------------------
// credit_tx_fifo2
// Two-entry FIFO holding packets awaiting an arbiter grant.
//   clk, reset  clock, synchronous active-high reset (empties the FIFO)
//   push_i      write din_i (ignored when full unless a pop happens too)
//   din_i       data to write
//   pop_i       remove head (ignored when empty)
//   dout_o      head entry, all zeros when empty
//   empty_o     no entries held
//   count_o     number of entries held (0..2)
// ---------------------------------------------------------------------------
module credit_tx_fifo2 #(
    parameter int W = 82
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         empty_o,
    output logic [1:0]   count_o
);
    logic [W-1:0] mem_q [2];
    logic         rd_ptr_q, rd_ptr_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         pop_ok;
    logic         push_ok;

    assign pop_ok  = pop_i && (count_q != 2'd0);
    assign push_ok = push_i && ((count_q != 2'd2) || pop_ok);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop_ok) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (push_ok) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        count_d = count_q + 2'(push_ok) - 2'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the output is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    assign empty_o = (count_q == 2'd0);
    assign count_o = count_q;
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/credit_stream_tx.sv
// ---------------------------------------------------------------------------
// credit_stream_tx
// Transmit endpoint of the leaf credit protocol. Packs user words into NoC
// data packets for a remote input port, spends one receiver credit per
// packet, and restores FREESPACE_UPDATE_SIZE credits for every freespace
// update packet addressed to (self_leaf, SELF_PORT).
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   self_leaf      this leaf's ID (static after reset)
//   cfg_vld        configuration valid (level); enters RUN when high
//   cfg_dst_leaf   destination leaf, latched on entry to RUN
//   cfg_dst_port   destination input port (1..8), latched on entry to RUN
//   bus            credit_stream_tx_if.slave: din/vld_user/ack_user,
//                  stream_in, pkt_out/pkt_vld/pkt_rd
//   credit         current credit count
//   stall_cycles   cycles spent in RUN with vld_user high and no credit
//                  (only with CREDIT_TX_STALL_CNT_EN defined)
//   state_dbg      current FSM state (0 = CFG_WAIT, 1 = RUN)
//
// Build option: define CREDIT_TX_STALL_CNT_EN to add the stall_cycles
// counter and port.
// ---------------------------------------------------------------------------
module credit_stream_tx
    import noc_pkt_pkg::*;
#(
    parameter int NUM_LEAF_BITS         = NOC_LEAF_BITS,
    parameter int NUM_PORT_BITS         = NOC_PORT_BITS,
    parameter int NUM_ADDR_BITS         = NOC_ADDR_BITS,
    parameter int PAYLOAD_BITS          = NOC_PAYLOAD_BITS,
    parameter int NUM_BRAM_ADDR_BITS    = 7,
    parameter int FREESPACE_UPDATE_SIZE = 64,
    parameter int SELF_PORT             = OUTPUT_PORT_MIN_NUM,
    localparam int PACKET_BITS          = 1 + NUM_LEAF_BITS + NUM_PORT_BITS
                                          + NUM_ADDR_BITS + PAYLOAD_BITS,
    localparam int CW                   = NUM_BRAM_ADDR_BITS + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_LEAF_BITS-1:0] self_leaf,
    input  logic                     cfg_vld,
    input  logic [NUM_LEAF_BITS-1:0] cfg_dst_leaf,
    input  logic [NUM_PORT_BITS-1:0] cfg_dst_port,
    credit_stream_tx_if.slave        bus,
    output logic [CW-1:0]            credit,
`ifdef CREDIT_TX_STALL_CNT_EN
    output logic [31:0]              stall_cycles,
`endif
    output logic [0:0]               state_dbg
);
    localparam logic [0:0] ST_CFG_WAIT = CFG_WAIT;
    localparam logic [0:0] ST_RUN      = RUN;

    // Field offsets derived from this instance's widths.
    localparam int ADDR_LSB  = PAYLOAD_BITS;
    localparam int PORT_LSB  = ADDR_LSB + NUM_ADDR_BITS;
    localparam int LEAF_LSB  = PORT_LSB + NUM_PORT_BITS;
    localparam int VALID_BIT = LEAF_LSB + NUM_LEAF_BITS;

    localparam logic [CW-1:0]            CREDIT_MAX = CW'((1 << NUM_BRAM_ADDR_BITS) - 1);
    localparam logic [NUM_PORT_BITS-1:0] SELF_PORT_F = NUM_PORT_BITS'(SELF_PORT);

    logic [0:0]               state_q, state_d;
    logic [NUM_LEAF_BITS-1:0] dst_leaf_q, dst_leaf_d;
    logic [NUM_PORT_BITS-1:0] dst_port_q, dst_port_d;
    logic [NUM_ADDR_BITS-1:0] addr_q, addr_d;
    logic [CW-1:0]            credit_q, credit_d;
    logic [31:0]              credit_sum;

    logic                     fifo_empty;
    logic [1:0]               fifo_count;
    logic [PACKET_BITS-1:0]   fifo_dout;
    logic [PACKET_BITS-1:0]   new_pkt;
    logic                     ack;
    logic                     accept;
    logic                     upd_hit;

    // ack depends only on registered state, so stream_in can never reach
    // ack_user combinationally.
    assign ack    = (state_q == ST_RUN) && (credit_q != '0) && (fifo_count < 2'd2);
    assign accept = ack && bus.vld_user;

    assign upd_hit = bus.stream_in[VALID_BIT]
                     && (bus.stream_in[LEAF_LSB +: NUM_LEAF_BITS] == self_leaf)
                     && (bus.stream_in[PORT_LSB +: NUM_PORT_BITS] == SELF_PORT_F);

    assign new_pkt = {1'b1, dst_leaf_q, dst_port_q, addr_q, bus.din};

    // FSM, destination capture and address counter.
    always_comb begin
        state_d    = state_q;
        dst_leaf_d = dst_leaf_q;
        dst_port_d = dst_port_q;
        addr_d     = addr_q;
        case (state_q)
            ST_CFG_WAIT: begin
                if (cfg_vld) begin
                    state_d    = ST_RUN;
                    dst_leaf_d = cfg_dst_leaf;
                    dst_port_d = cfg_dst_port;
                    addr_d     = '0;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    addr_d = addr_q + 1'b1;
                end
                // Leaving RUN waits for buffered packets to drain.
                if (!cfg_vld && fifo_empty) begin
                    state_d = ST_CFG_WAIT;
                end
            end
            default: state_d = ST_CFG_WAIT;
        endcase
    end

    // Credit: add the update and subtract the accept in a wide sum, then
    // saturate. accept implies credit_q != 0, so the sum never goes negative.
    always_comb begin
        credit_sum = 32'(credit_q);
        if (upd_hit) begin
            credit_sum = credit_sum + 32'(FREESPACE_UPDATE_SIZE);
        end
        if (accept) begin
            credit_sum = credit_sum - 32'd1;
        end
        if (credit_sum > 32'(CREDIT_MAX)) begin
            credit_d = CREDIT_MAX;
        end else begin
            credit_d = credit_sum[CW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_CFG_WAIT;
            dst_leaf_q <= '0;
            dst_port_q <= '0;
            addr_q     <= '0;
            credit_q   <= CREDIT_MAX;
        end else begin
            state_q    <= state_d;
            dst_leaf_q <= dst_leaf_d;
            dst_port_q <= dst_port_d;
            addr_q     <= addr_d;
            credit_q   <= credit_d;
        end
    end

    credit_tx_fifo2 #(
        .W (PACKET_BITS)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (accept),
        .din_i   (new_pkt),
        .pop_i   (bus.pkt_rd),
        .dout_o  (fifo_dout),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

`ifdef CREDIT_TX_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if ((state_q == ST_RUN) && bus.vld_user && (credit_q == '0)
            && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

    assign bus.ack_user = ack;
    assign bus.pkt_vld  = !fifo_empty;
    assign bus.pkt_out  = fifo_dout;
    assign credit       = credit_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_credit_stream_tx.sv
// ---------------------------------------------------------------------------
// tb_credit_stream_tx
// Self-checking bench for credit_stream_tx. Inputs change 1 time unit after
// the rising edge; outputs are observed on the falling edge. Accepted user
// words are turned into expected packets and queued; every packet popped by
// the arbiter is compared against the queue head.
// ---------------------------------------------------------------------------
module tb_credit_stream_tx;
    import noc_pkt_pkg::*;

    localparam int PB = NOC_PACKET_BITS;

    logic       clk;
    logic       reset;
    logic [5:0] self_leaf;
    logic       cfg_vld;
    logic [5:0] cfg_dst_leaf;
    logic [3:0] cfg_dst_port;
    logic [7:0] credit;
    logic [0:0] state_dbg;
`ifdef CREDIT_TX_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    credit_stream_tx_if #(.PAYLOAD_BITS(NOC_PAYLOAD_BITS), .PACKET_BITS(PB)) bus ();

    credit_stream_tx dut (
        .clk          (clk),
        .reset        (reset),
        .self_leaf    (self_leaf),
        .cfg_vld      (cfg_vld),
        .cfg_dst_leaf (cfg_dst_leaf),
        .cfg_dst_port (cfg_dst_port),
        .bus          (bus),
        .credit       (credit),
`ifdef CREDIT_TX_STALL_CNT_EN
        .stall_cycles (stall_cycles),
`endif
        .state_dbg    (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [PB-1:0] exp_q[$];
    logic [5:0]    exp_leaf;
    logic [3:0]    exp_port;
    logic [6:0]    exp_addr;
    int            errors = 0;
    int            checks = 0;
    int            acc_count = 0;
    int            pop_count = 0;
    int            cyc_n = 0;
    int            first_acc = -1;
    int            first_vld = -1;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Monitor / scoreboard on the falling edge.
    always @(negedge clk) begin
        logic [PB-1:0] e;
        if (!reset) begin
            if (bus.vld_user && bus.ack_user) begin
                exp_q.push_back({1'b1, exp_leaf, exp_port, exp_addr, bus.din});
                exp_addr = exp_addr + 7'd1;
                acc_count++;
                if (first_acc < 0) first_acc = cyc_n;
            end
            if (bus.pkt_vld && first_vld < 0) first_vld = cyc_n;
            if (bus.pkt_vld && bus.pkt_rd) begin
                check("sb_has_expected", 96'(exp_q.size() != 0), 96'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("pkt_out", 96'(bus.pkt_out), 96'(e));
                end
                pop_count++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic configure(input logic [5:0] leaf, input logic [3:0] port);
        cfg_vld      = 1'b1;
        cfg_dst_leaf = leaf;
        cfg_dst_port = port;
        exp_leaf     = leaf;
        exp_port     = port;
        exp_addr     = 7'd0;
        tick();
        check("state_run", 96'(state_dbg), 96'd1);
    endtask

    task automatic send_beats(input int n);
        int sent = 0;
        int cyc = 0;
        while (sent < n && cyc < n + 50) begin
            bus.vld_user = 1'b1;
            bus.din      = {$urandom, $urandom};
            @(negedge clk);
            if (bus.ack_user) sent++;
            tick();
            cyc++;
        end
        bus.vld_user = 1'b0;
        if (sent != n) check("send_timeout", 96'(sent), 96'(n));
    endtask

    function automatic logic [PB-1:0] mk_pkt(input logic v, input logic [5:0] leaf,
                                             input logic [3:0] port);
        logic [PB-1:0] p;
        p = '0;
        p[PKT_VALID_BIT] = v;
        p[PKT_LEAF_LSB +: NOC_LEAF_BITS] = leaf;
        p[PKT_PORT_LSB +: NOC_PORT_BITS] = port;
        p[PKT_PAYLOAD_LSB +: NOC_PAYLOAD_BITS] = 64'h0000_0000_dead_beef;
        return p;
    endfunction

    task automatic inject(input logic [PB-1:0] p);
        bus.stream_in = p;
        tick();
        bus.stream_in = '0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ack"},    96'(bus.ack_user), 96'd0);
        check({tag, "_vld"},    96'(bus.pkt_vld),  96'd0);
        check({tag, "_pkt"},    96'(bus.pkt_out),  96'd0);
        check({tag, "_credit"}, 96'(credit),       96'd127);
        check({tag, "_state"},  96'(state_dbg),    96'd0);
`ifdef CREDIT_TX_STALL_CNT_EN
        check({tag, "_stall"},  96'(stall_cycles), 96'd0);
`endif
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int a0;
        int p0;
        int w;
        reset         = 1'b1;
        self_leaf     = 6'd5;
        cfg_vld       = 1'b0;
        cfg_dst_leaf  = '0;
        cfg_dst_port  = '0;
        bus.din       = '0;
        bus.vld_user  = 1'b0;
        bus.stream_in = '0;
        bus.pkt_rd    = 1'b0;
        exp_leaf      = '0;
        exp_port      = '0;
        exp_addr      = '0;

        do_reset();
        check_reset_state("reset");

        // Five beats to (3,2) with the arbiter always granting.
        bus.pkt_rd = 1'b1;
        configure(6'd3, 4'd2);
        first_acc = -1;
        first_vld = -1;
        a0 = acc_count;
        p0 = pop_count;
        send_beats(5);
        repeat (3) tick();
        check("t1_credit", 96'(credit), 96'd122);
        check("t1_accepts", 96'(acc_count - a0), 96'd5);
        check("t1_pops", 96'(pop_count - p0), 96'd5);
        check("t1_first_latency", 96'(first_vld - first_acc), 96'd1);

        // Drain all 127 credits from a fresh reset.
        do_reset();
        configure(6'd3, 4'd2);
        send_beats(127);
        check("t2_credit_zero", 96'(credit), 96'd0);
        check("t2_ack_low", 96'(bus.ack_user), 96'd0);

        // Twenty stalled cycles at zero credit.
        bus.vld_user = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        bus.vld_user = 1'b0;
        check("t2_still_stalled", 96'(credit), 96'd0);
`ifdef CREDIT_TX_STALL_CNT_EN
        check("t2_stall_cycles", 96'(stall_cycles), 96'd20);
`endif

        // Update restores credit on the next cycle, never in the same one.
        bus.stream_in = mk_pkt(1'b1, self_leaf, 4'(OUTPUT_PORT_MIN_NUM));
        @(negedge clk);
        check("t2_ack_no_comb", 96'(bus.ack_user), 96'd0);
        tick();
        bus.stream_in = '0;
        check("t2_ack_after_upd", 96'(bus.ack_user), 96'd1);
        check("t2_credit_64", 96'(credit), 96'd64);

        // Misaddressed or invalid updates are ignored.
        inject(mk_pkt(1'b1, self_leaf + 6'd1, 4'd9));
        check("t3_wrong_leaf", 96'(credit), 96'd64);
        inject(mk_pkt(1'b1, self_leaf, 4'd5));
        check("t3_wrong_port", 96'(credit), 96'd64);
        inject(mk_pkt(1'b0, self_leaf, 4'd9));
        check("t3_not_valid", 96'(credit), 96'd64);

        // Accept and update in the same cycle at credit 10.
        send_beats(54);
        check("t4_credit_10", 96'(credit), 96'd10);
        bus.vld_user  = 1'b1;
        bus.din       = {$urandom, $urandom};
        bus.stream_in = mk_pkt(1'b1, self_leaf, 4'd9);
        @(negedge clk);
        check("t4_ack_at_10", 96'(bus.ack_user), 96'd1);
        tick();
        bus.vld_user  = 1'b0;
        bus.stream_in = '0;
        check("t4_credit_73", 96'(credit), 96'd73);

        // Saturation.
        inject(mk_pkt(1'b1, self_leaf, 4'd9));
        check("t4_sat_from_73", 96'(credit), 96'd127);
        send_beats(27);
        check("t4_credit_100", 96'(credit), 96'd100);
        bus.stream_in = mk_pkt(1'b1, self_leaf, 4'd9);
        tick();
        tick();
        bus.stream_in = '0;
        check("t4_sat_two_upd", 96'(credit), 96'd127);
        repeat (3) tick();

        // Back-pressure: FIFO fills with exactly two packets.
        bus.pkt_rd = 1'b0;
        a0 = acc_count;
        bus.vld_user = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.din = {$urandom, $urandom};
            tick();
        end
        @(negedge clk);
        check("t5_ack_full", 96'(bus.ack_user), 96'd0);
        check("t5_two_accepted", 96'(acc_count - a0), 96'd2);
        tick();
        bus.vld_user = 1'b0;
        check("t5_credit", 96'(credit), 96'd125);
        p0 = pop_count;
        bus.pkt_rd = 1'b1;
        repeat (4) tick();
        check("t5_two_popped", 96'(pop_count - p0), 96'd2);
        check("t5_sb_empty", 96'(exp_q.size()), 96'd0);

        // Reset with two packets buffered.
        bus.pkt_rd = 1'b0;
        send_beats(2);
        check("t6_buffered", 96'(bus.pkt_vld), 96'd1);
        reset = 1'b1;
        exp_q.delete();
        tick();
        check_reset_state("t6_mid_reset");
        reset   = 1'b0;
        cfg_vld = 1'b0;
        tick();

        // Config changes in RUN are ignored; leaving RUN waits for drain;
        // re-entry latches new destination and restarts addr at 0.
        bus.pkt_rd = 1'b1;
        configure(6'd7, 4'd4);
        send_beats(2);
        cfg_dst_leaf = 6'd1;
        cfg_dst_port = 4'd1;
        send_beats(2);
        cfg_vld = 1'b0;
        w = 0;
        while (state_dbg != 1'b0 && w < 10) begin
            tick();
            w++;
        end
        check("t7_back_to_cfg", 96'(state_dbg), 96'd0);
        check("t7_ack_in_cfg", 96'(bus.ack_user), 96'd0);
        configure(6'd1, 4'd1);
        send_beats(3);
        repeat (3) tick();
        check("t7_sb_empty", 96'(exp_q.size()), 96'd0);
        check("t7_credit", 96'(credit), 96'd120);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/credit_stream_tx.md
Name: credit_stream_tx

Overview:
- Transmit endpoint of the leaf credit protocol: packs user words into NoC data packets for a remote input port, and spends receiver credits as it sends.
- Absorbs freespace-update packets addressed to its own output port and restores credit by FREESPACE_UPDATE_SIZE per update.
- Sits between user logic and the leaf converge arbiter. Presents one packet at a time through a vld/rd_en pair.
- Single clock domain: clk.

Parameters:
- NUM_LEAF_BITS, 6, leaf ID field width
- NUM_PORT_BITS, 4, port field width
- NUM_ADDR_BITS, 7, packet address field width
- PAYLOAD_BITS, 64, user data width
- NUM_BRAM_ADDR_BITS, 7, receiver buffer depth is 2^N entries
- FREESPACE_UPDATE_SIZE, 64, credits restored per update packet
- SELF_PORT, 9, this output port number; legal range is 9 or higher
- PACKET_BITS (localparam), 1+NUM_LEAF_BITS+NUM_PORT_BITS+NUM_ADDR_BITS+PAYLOAD_BITS

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- self_leaf  in  NUM_LEAF_BITS  this leaf's ID; static after reset
- cfg_vld  in  1  configuration valid; level signal
- cfg_dst_leaf  in  NUM_LEAF_BITS  destination leaf
- cfg_dst_port  in  NUM_PORT_BITS  destination input port; legal range 1..8
- din  in  PAYLOAD_BITS  user data
- vld_user  in  1  user data valid
- ack_user  out  1  beat accepted this cycle when vld_user && ack_user
- stream_in  in  PACKET_BITS  incoming packets, sampled when bit MSB = 1
- pkt_out  out  PACKET_BITS  head packet
- pkt_vld  out  1  head packet is valid
- pkt_rd  in  1  arbiter grant; pops the head
- credit  out  NUM_BRAM_ADDR_BITS+1  current credit count
- stall_cycles  out  32  only present with STALL_CNT_EN

Behaviour:
- Packet layout, MSB to LSB: valid, dst_leaf, dst_port, addr, payload.
- States:
  - CFG_WAIT (reset state) goes to RUN when cfg_vld = 1.
  - RUN goes to CFG_WAIT when cfg_vld = 0 and the buffer is empty. While the buffer is non-empty, cfg_vld = 0 is ignored until the buffer drains.
  - In RUN, ack_user = (credit != 0) && (buffer count < 2). ack_user = 0 in CFG_WAIT.
- Configuration capture:
  - dst_leaf and dst_port are latched on the CFG_WAIT -> RUN transition.
  - Changes to cfg_* while in RUN have no effect.
- Buffer: 2-entry FIFO.
  - An accepted beat at cycle N appears on pkt_out with pkt_vld = 1 at cycle N+1 if the FIFO was empty.
  - A push and a pop in the same cycle are both allowed.
  - pkt_rd while pkt_vld = 0 is ignored.
  - pkt_out is all zeros when the FIFO is empty.
- addr field:
  - NUM_ADDR_BITS counter, starts at 0, increments per accepted beat, wraps modulo 2^NUM_ADDR_BITS.
  - The counter resets to 0 on each entry to RUN.
- Credit accounting:
  - Reset value is 2^NUM_BRAM_ADDR_BITS - 1.
  - Decrements by 1 per accepted beat.
  - A freespace-update hit is stream_in[MSB] = 1 && dst_leaf == self_leaf && dst_port == SELF_PORT. Each hit adds FREESPACE_UPDATE_SIZE.
  - An accept and an update in the same cycle give a net change of +SIZE-1.
  - The sum saturates at 2^NUM_BRAM_ADDR_BITS - 1.
  - Packets that miss the hit check are ignored. Updates are honoured in both states.
- Boundaries:
  - Credit = 0: ack_user = 0. An update arriving in that cycle makes ack_user = 1 from the next cycle; there is no combinational path from stream_in to ack_user.
  - FIFO full: ack_user = 0.
- Reset values:
  - Outputs: ack_user = 0, pkt_vld = 0, pkt_out = 0, credit = 2^N - 1, stall_cycles = 0.
  - State: CFG_WAIT; FIFO and addr cleared.
- Reset mid-operation discards buffered packets. Credits are not reconciled with the receiver, which must be reset in the same cycle.

Optional Feature:
- Macro: CREDIT_TX_STALL_CNT_EN.
- Defined:
  - stall_cycles increments on every cycle with state == RUN && vld_user && credit == 0.
  - Saturates at 2^32 - 1; cleared only by reset.
- Undefined: the stall_cycles port and its counter are absent.

Decomposition:
- Shared package noc_pkt_pkg holds:
  - field-width localparams and the packet field offset constants;
  - INPUT_PORT_MAX_NUM = 8 and OUTPUT_PORT_MIN_NUM = 9;
  - state enum {CFG_WAIT, RUN}.
- One sub-module: credit_tx_fifo2, the 2-entry FIFO with count output.
- Credit logic, address counter and FSM stay in the top level.

Test Plan:
- Reset, cfg_vld = 1, dst = (leaf 3, port 2), 5 beats with pkt_rd held at 1:
  - 5 packets, addr 0..4, dst field 3/2;
  - credit falls from 127 to 122;
  - first pkt_vld one cycle after the first accept.
- 127 beats with no updates:
  - ack_user drops after the 127th beat;
  - inject one update to (self_leaf, port 9): ack_user = 1 next cycle, credit = 64.
- Update to a wrong leaf, then a wrong port (5): credit unchanged.
- Accept and update in the same cycle at credit 10: credit = 73. Two updates from credit 100: credit saturates at 127.
- pkt_rd = 0 for 10 cycles with vld_user = 1:
  - exactly 2 beats accepted, ack_user = 0 thereafter;
  - release pkt_rd: packets come out in order, no loss or duplication.
- Reset asserted with 2 packets buffered: next cycle pkt_vld = 0, credit = 127, state CFG_WAIT. With CREDIT_TX_STALL_CNT_EN defined, 20 stalled cycles give stall_cycles = 20.
